// File: rtl/pc_sequencer_pkg.sv
// Shared next-PC mode encodings and constants for the PC sequencer and its RAS.
package pc_seq_pkg;

  localparam int PC_SEL_W = 3;
  localparam int PC_INC   = 4;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_JAL  = 3'd2,
    PC_JALR = 3'd3,
    PC_TRAP = 3'd4,
    PC_RET  = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/target bus between the pipeline front end (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int XLEN = 32
) ();

  logic                            stall;
  logic [pc_seq_pkg::PC_SEL_W-1:0] pc_sel;
  logic                            ctrl_branch;
  logic                            alu_zero;
  logic [XLEN-1:0]                 immediate;
  logic [XLEN-1:0]                 rs1;
  logic [XLEN-1:0]                 trap_vec;
  logic                            is_call;
  logic [XLEN-1:0]                 pc;
  logic [XLEN-1:0]                 pc_plus4;
  logic                            misalign;
  logic                            ras_valid;

  modport master (
    output stall, pc_sel, ctrl_branch, alu_zero, immediate, rs1, trap_vec, is_call,
    input  pc, pc_plus4, misalign, ras_valid
  );

  modport slave (
    input  stall, pc_sel, ctrl_branch, alu_zero, immediate, rs1, trap_vec, is_call,
    output pc, pc_plus4, misalign, ras_valid
  );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push to a full stack overwrites the oldest entry.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   sp_p1;
  logic [CW-1:0]   cnt_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(RAS_DEPTH)) ? c : c + CW'(1);
  endfunction

  // sp_p1 is the next free slot; the top entry sits one below it
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sp_p1  <= '0;
      cnt_p1 <= '0;
    end else if (push) begin
      sp_p1  <= sp_p1 + PW'(1);
      cnt_p1 <= sat_inc(cnt_p1);
    end else if (pop && cnt_p1 != '0) begin
      sp_p1  <= sp_p1 - PW'(1);
      cnt_p1 <= cnt_p1 - CW'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem[sp_p1] <= wdata;
  end

  assign top   = mem[sp_p1 - PW'(1)];
  assign valid = (cnt_p1 != '0);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and PC register with misalignment trap redirect.
// Optional return-address stack is compiled in with macro PC_SEQ_RAS_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC0 = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] RESET_VEC1 = XLEN'(32'h0000_0040),
  parameter int              RAS_DEPTH  = 4
) (
  input  logic           sysclk,
  input  logic           reset,
  input  logic           s0,
  pc_sequencer_if.slave  bus
);

  logic        [XLEN-1:0] pc_p1;
  logic                   misalign_p1;
  logic        [XLEN-1:0] pc_plus4;
  logic signed [XLEN-1:0] imm_s;
  logic        [XLEN-1:0] rel_tgt;
  logic        [XLEN-1:0] jalr_tgt;
  logic        [XLEN-1:0] target;
  logic        [XLEN-1:0] pc_next;
  logic                   is_trap;
  logic                   bad;
  logic                   push_req;
  logic                   pop_req;
  logic                   push;
  logic                   pop;
  logic        [XLEN-1:0] ras_top;
  logic                   ras_valid;

  assign imm_s = bus.immediate;

  always_comb begin
    pc_plus4 = pc_p1 + XLEN'(PC_INC);
    rel_tgt  = pc_p1 + imm_s;
    jalr_tgt = (bus.rs1 + imm_s) & ~XLEN'(1);
    target   = pc_plus4;
    is_trap  = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    case (bus.pc_sel)
      PC_BR:   if (bus.ctrl_branch && bus.alu_zero) target = rel_tgt;
      PC_JAL:  begin target = rel_tgt;  push_req = bus.is_call; end
      PC_JALR: begin target = jalr_tgt; push_req = bus.is_call; end
      PC_TRAP: begin target = bus.trap_vec; is_trap = 1'b1; end
      PC_RET: begin
        if (ras_valid) begin
          target  = ras_top;
          pop_req = 1'b1;
        end else begin
          target = jalr_tgt;
        end
      end
      default: ;
    endcase
    // a misaligned target redirects to the trap handler and never touches the RAS
    bad     = !is_trap && (target[1:0] != 2'b00);
    pc_next = bad ? bus.trap_vec : target;
    push    = push_req && !bad && !bus.stall;
    pop     = pop_req && !bad && !bus.stall;
  end

`ifdef PC_SEQ_RAS_EN
  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wdata  (pc_plus4),
    .top    (ras_top),
    .valid  (ras_valid)
  );
`else
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
  assign unused_ras = push ^ pop;
`endif

  // stage p1: architectural PC and misalign pulse
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pc_p1       <= s0 ? RESET_VEC1 : RESET_VEC0;
      misalign_p1 <= 1'b0;
    end else if (!bus.stall) begin
      pc_p1       <= pc_next;
      misalign_p1 <= bad;
    end
  end

  assign bus.pc        = pc_p1;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.misalign  = misalign_p1;
  assign bus.ras_valid = ras_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  logic s0     = 1'b1;

  pc_sequencer_if #(.XLEN(32)) bus ();

  pc_sequencer #(
    .XLEN       (32),
    .RESET_VEC0 (32'h0000_0000),
    .RESET_VEC1 (32'h0000_0040),
    .RAS_DEPTH  (DEPTH)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .s0     (s0),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
    chk({tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, m_mis});
    chk({tag, ".ras_valid"}, {31'd0, bus.ras_valid}, {31'd0, RAS_EN && (m_ras.size() != 0)});
  endtask

  task automatic drive(input int mode, input bit st, input bit cb, input bit az,
                       input logic [31:0] imm, input logic [31:0] r1,
                       input logic [31:0] tv, input bit call);
    bus.pc_sel      = 3'(mode);
    bus.stall       = st;
    bus.ctrl_branch = cb;
    bus.alu_zero    = az;
    bus.immediate   = imm;
    bus.rs1         = r1;
    bus.trap_vec    = tv;
    bus.is_call     = call;
  endtask

  task automatic model_reset();
    m_pc  = s0 ? 32'h40 : 32'h0;
    m_mis = 1'b0;
    m_ras.delete();
  endtask

  // Reference: compute the target from the mode rules, then apply redirect and RAS effects.
  function automatic void predict();
    logic [31:0] tgt;
    logic [31:0] jalr;
    logic        mis;
    int          mode;
    mode = int'(bus.pc_sel);
    jalr = (bus.rs1 + bus.immediate) & 32'hFFFF_FFFE;
    case (mode)
      1:       tgt = (bus.ctrl_branch && bus.alu_zero) ? m_pc + bus.immediate : m_pc + 32'd4;
      2:       tgt = m_pc + bus.immediate;
      3:       tgt = jalr;
      4:       tgt = bus.trap_vec;
      5:       tgt = (RAS_EN && m_ras.size() != 0) ? m_ras[m_ras.size()-1] : jalr;
      default: tgt = m_pc + 32'd4;
    endcase
    mis = (mode != 4) && (tgt[1:0] != 2'b00);
    if (bus.stall) return;
    if (RAS_EN && !mis) begin
      if ((mode == 2 || mode == 3) && bus.is_call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (mode == 5 && m_ras.size() != 0) begin
        void'(m_ras.pop_back());
      end
    end
    m_mis = mis;
    m_pc  = mis ? bus.trap_vec : tgt;
  endfunction

  task automatic step(input string tag);
    predict();
    @(posedge sysclk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] imm;
    logic [31:0] r1;
    drive(0, 0, 0, 0, 32'd0, 32'd0, 32'h800, 0);
    reset = 1'b1;
    s0    = 1'b1;
    #12;
    model_reset();
    check_all("reset_s0");

    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("seq");

    // branch not-taken then taken with a negative offset
    drive(4, 0, 0, 0, 32'd0, 32'd0, 32'h100, 0);
    step("trap100");
    drive(1, 0, 1, 0, 32'hFFFF_FFF8, 32'd0, 32'h800, 0);
    step("br_nt");
    drive(1, 0, 1, 1, 32'hFFFF_FFF8, 32'd0, 32'h800, 0);
    step("br_t");

    // JALR to 0x302 is misaligned and redirects to trap_vec
    drive(4, 0, 0, 0, 32'd0, 32'd0, 32'h200, 0);
    step("trap200");
    drive(3, 0, 0, 0, 32'h2, 32'h301, 32'h800, 0);
    step("jalr_mis");
    drive(1, 1, 0, 0, 32'd0, 32'd0, 32'h800, 0);
    step("stall_hold_mis");
    drive(0, 0, 0, 0, 32'd0, 32'd0, 32'h800, 0);
    step("mis_clear");

    // undefined encodings and wrap-around
    drive(4, 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFC, 0);
    step("trap_top");
    drive(6, 0, 0, 0, 32'd0, 32'd0, 32'h800, 0);
    step("undef6_wrap");
    drive(7, 0, 0, 0, 32'd0, 32'd0, 32'h800, 0);
    step("undef7");

    // five calls, a stalled call in the middle, then five returns
    drive(4, 0, 0, 0, 32'd0, 32'd0, 32'h10, 0);
    step("trap10");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        drive(2, 1, 0, 0, 32'h10, 32'd0, 32'h800, 1);
        for (int k = 0; k < 3; k++) step("jal_stall");
      end
      drive(2, 0, 0, 0, 32'h10, 32'd0, 32'h800, 1);
      step("jal_call");
    end
    drive(5, 0, 0, 0, 32'd0, 32'h900, 32'h800, 0);
    for (int i = 0; i < 5; i++) step("ret");
    step("ret_empty");

    // reset asserted between edges while stalled, with s0=0
    drive(2, 1, 0, 0, 32'h10, 32'd0, 32'h800, 1);
    #2;
    s0    = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid");
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    check_all("reset_held");
    drive(0, 0, 0, 0, 32'd0, 32'd0, 32'h800, 0);
    step("post_reset");

    for (int i = 0; i < 400; i++) begin
      imm = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 1) == 1) imm = -imm;
      if ($urandom_range(0, 7) == 0) imm = imm + 32'($urandom_range(1, 3));
      r1  = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
      drive($urandom_range(0, 7), $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom),
            imm, r1, $urandom & 32'h0000_FFFC, 1'($urandom));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
